ysyx_25020047_lsu: RTL and testbench
====================================

Name: ysyx_25020047_lsu

Overview:
Load/store unit directly downstream of the execute stage. Takes the ALU result, store data and read/write strobes, and performs at most one memory access per instruction over a valid/ready request plus response-valid bus. Handles byte lane selection, store masks, load sign/zero extension, misalignment and bus timeout. Hands the final writeback value and register-write enable to the register file stage.

Parameters:
TIMEOUT, 255, max cycles spent in REQ+RESP before aborting with error (must be ≥2)

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
in_valid  in  1  execute result valid
in_ready  out  1  LSU can accept (high only in IDLE)
in_result  in  32  ALU result: byte address for memory ops, writeback value otherwise
in_wdata  in  32  store data (rs2 value)
in_read  in  1  load op
in_write  in  1  store op
in_size  in  2  0=byte, 1=half, 2=word, 3=illegal
in_unsigned  in  1  zero-extend load (lbu/lhu)
in_reg_wen  in  1  execute-stage register write enable
out_valid  out  1  writeback result valid
out_ready  in  1  writeback stage accepts
out_wb_data  out  32  writeback value
out_reg_wen  out  1  register write enable
out_err  out  1  access fault (misaligned, read&write both set, illegal size, timeout)
mem_req_valid  out  1  memory request valid
mem_req_ready  in  1  memory accepts request
mem_req_addr  out  32  word-aligned address ({addr[31:2],2'b00})
mem_req_wen  out  1  1=write
mem_req_wdata  out  32  lane-replicated store data
mem_req_wmask  out  4  byte enables (0000 for reads)
mem_resp_valid  in  1  read data ready / write acknowledged
mem_resp_rdata  in  32  read word

Behaviour:
- Clock and reset: one clock `clk`; `rst` is synchronous and active-high. While rst is high at a rising edge: state←IDLE, timeout counter←0, all captured registers←0.
- Reset values: mem_req_valid=0, out_valid=0, out_err=0, out_reg_wen=0, out_wb_data=0, mem_req_wmask=0. in_ready=1 because the state is IDLE.
- States: IDLE, REQ, RESP, DONE. All outputs are decoded from the state and registered fields.
- IDLE: in_ready=1. When in_valid=1, capture all inputs and:
  - read&&write, size==3, half with addr[0]≠0, or word with addr[1:0]≠0 → DONE with err=1.
  - Neither read nor write → DONE with wb_data=in_result, reg_wen=in_reg_wen.
  - Otherwise → REQ with the timeout counter cleared.
- REQ: mem_req_valid=1 and request fields are held stable. When mem_req_ready=1 → RESP.
- RESP: when mem_resp_valid=1 → DONE.
  - Load: wb_data=extracted data, reg_wen=1.
  - Store: wb_data=0, reg_wen=0.
  - mem_resp_valid is ignored in any other state, including the accept cycle in REQ. Memory must respond at least one cycle after it accepts.
- Timeout: the counter increments each cycle in REQ or RESP. If it equals TIMEOUT-1 without a transition → DONE with err=1. Timeout takes priority over a transition in the same cycle.
- DONE: out_valid=1 with outputs held. When out_ready=1 → IDLE. A new input can be accepted on the following cycle, not in the same cycle.
- Error: out_err=1, out_reg_wen=0, out_wb_data=0, and no bus request is issued.
- Store lanes, with o=addr[1:0]:
  - byte: wmask=4'b0001<<o, wdata={4{wdata[7:0]}}.
  - half: wmask=o[1]?1100:0011, wdata={2{wdata[15:0]}}.
  - word: wmask=1111, wdata=wdata.
- Load extraction: shifted = rdata >> (8*o).
  - byte: sign- or zero-extend shifted[7:0].
  - half: sign- or zero-extend shifted[15:0].
  - word: rdata unchanged.
- Latency:
  - Non-memory op: accepted at edge N, out_valid from N+1.
  - Memory op with ready granted immediately and response one cycle later: req_valid N+1, response N+2, out_valid N+3.
- Reset mid-operation: the transaction is abandoned and mem_req_valid is 0 after the reset edge. A late mem_resp_valid arriving in IDLE is ignored.

Test Plan:
1. Non-memory op: in_result=0x1234, reg_wen=1 → out_valid next cycle, wb_data=0x00001234, reg_wen=1, no mem_req_valid.
2. lbu and lb at addr 0x80000003, rdata=0x80FF7F11:
   - lbu → wb=0x00000080.
   - lb → wb=0xFFFFFF80.
   - req_addr=0x80000000, wmask=0000 in both cases.
3. sb at addr 0x80000002 with wdata=0xDEADBEEF → wmask=0100, mem_wdata=0xEFEFEFEF, req_wen=1; after response, out_reg_wen=0, err=0.
4. sh at 0x80000001 and lw at 0x80000006 → err=1 next cycle, no bus request. read=write=1 → err=1.
5. Stall and timeout:
   - Hold mem_req_ready=0 for 3 cycles → req fields stable, then normal completion.
   - With TIMEOUT=8 and ready never asserted → out_err=1 exactly 8 cycles after entering REQ.
   - out_ready held low 4 cycles in DONE → outputs stable and in_ready=0.
6. Assert rst in RESP state → next cycle IDLE, all outputs 0, in_ready=1; a subsequent mem_resp_valid pulse produces no out_valid.

Source files
------------

// File: rtl/ysyx_25020047_lsu_if.sv
// Bundle of the LSU's pipeline handshakes and memory bus.
// The master modport is the LSU itself. The slave modport is the surrounding pipeline and memory.
interface ysyx_25020047_lsu_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_result;
    logic [31:0] in_wdata;
    logic        in_read;
    logic        in_write;
    logic [1:0]  in_size;
    logic        in_unsigned;
    logic        in_reg_wen;

    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_wb_data;
    logic        out_reg_wen;
    logic        out_err;

    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_req_addr;
    logic        mem_req_wen;
    logic [31:0] mem_req_wdata;
    logic [3:0]  mem_req_wmask;
    logic        mem_resp_valid;
    logic [31:0] mem_resp_rdata;

    modport master (
        input  in_valid, in_result, in_wdata, in_read, in_write, in_size, in_unsigned, in_reg_wen,
        output in_ready,
        output out_valid, out_wb_data, out_reg_wen, out_err,
        input  out_ready,
        output mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wmask,
        input  mem_req_ready, mem_resp_valid, mem_resp_rdata
    );

    modport slave (
        output in_valid, in_result, in_wdata, in_read, in_write, in_size, in_unsigned, in_reg_wen,
        input  in_ready,
        input  out_valid, out_wb_data, out_reg_wen, out_err,
        output out_ready,
        output mem_req_ready, mem_resp_valid, mem_resp_rdata,
        input  mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wmask
    );
endinterface

// File: rtl/ysyx_25020047_lsu.sv
// Load/store unit: performs one memory access per instruction, with lane steering, load extension,
// misalignment faults and a bus timeout.
module ysyx_25020047_lsu #(
    parameter int TIMEOUT = 255
) (
    input logic clk,
    input logic rst,
    ysyx_25020047_lsu_if.master bus
);
    localparam int CW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_t;

    state_t        state_reg;
    logic [CW-1:0] cnt_reg;
    logic [31:0]   addr_reg;
    logic [31:0]   wdata_reg;
    logic [3:0]    wmask_reg;
    logic          wen_reg;
    logic [1:0]    size_reg;
    logic          unsigned_reg;
    logic [31:0]   wb_data_reg;
    logic          reg_wen_reg;
    logic          err_reg;

    logic [1:0]  in_off;
    logic        in_bad;
    logic [3:0]  store_mask;
    logic [31:0] store_wdata;
    logic [7:0]  load_byte;
    logic [15:0] load_half;
    logic [31:0] load_value;
    logic        timed_out;

    assign in_off = bus.in_result[1:0];
    assign in_bad = (bus.in_read && bus.in_write) || (bus.in_size == 2'd3)
                 || (bus.in_size == 2'd1 && in_off[0])
                 || (bus.in_size == 2'd2 && in_off != 2'd0);

    // Store data is replicated across lanes so the mask alone selects the written bytes.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            localparam logic [1:0] LANE = 2'(gi);
            assign store_mask[gi] = (bus.in_size == 2'd0) ? (in_off == LANE)
                                  : (bus.in_size == 2'd1) ? (in_off[1] == LANE[1])
                                  : 1'b1;
            assign store_wdata[8*gi +: 8] = (bus.in_size == 2'd0) ? bus.in_wdata[7:0]
                                          : (bus.in_size == 2'd1) ? bus.in_wdata[8*(gi%2) +: 8]
                                          : bus.in_wdata[8*gi +: 8];
        end
    endgenerate

    assign load_byte = bus.mem_resp_rdata[{addr_reg[1:0], 3'b000} +: 8];
    assign load_half = addr_reg[1] ? bus.mem_resp_rdata[31:16] : bus.mem_resp_rdata[15:0];

    always_comb begin
        load_value = bus.mem_resp_rdata;
        case (size_reg)
            2'd0: load_value = unsigned_reg ? {24'd0, load_byte} : {{24{load_byte[7]}}, load_byte};
            2'd1: load_value = unsigned_reg ? {16'd0, load_half} : {{16{load_half[15]}}, load_half};
            default: load_value = bus.mem_resp_rdata;
        endcase
    end

    assign timed_out = (cnt_reg == CW'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            cnt_reg      <= '0;
            addr_reg     <= '0;
            wdata_reg    <= '0;
            wmask_reg    <= '0;
            wen_reg      <= 1'b0;
            size_reg     <= '0;
            unsigned_reg <= 1'b0;
            wb_data_reg  <= '0;
            reg_wen_reg  <= 1'b0;
            err_reg      <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: if (bus.in_valid) begin
                    addr_reg     <= bus.in_result;
                    wdata_reg    <= store_wdata;
                    wmask_reg    <= bus.in_write ? store_mask : 4'b0000;
                    wen_reg      <= bus.in_write;
                    size_reg     <= bus.in_size;
                    unsigned_reg <= bus.in_unsigned;
                    cnt_reg      <= '0;
                    if (in_bad) begin
                        err_reg     <= 1'b1;
                        wb_data_reg <= '0;
                        reg_wen_reg <= 1'b0;
                        state_reg   <= DONE;
                    end else if (!bus.in_read && !bus.in_write) begin
                        err_reg     <= 1'b0;
                        wb_data_reg <= bus.in_result;
                        reg_wen_reg <= bus.in_reg_wen;
                        state_reg   <= DONE;
                    end else begin
                        err_reg     <= 1'b0;
                        wb_data_reg <= '0;
                        reg_wen_reg <= 1'b0;
                        state_reg   <= REQ;
                    end
                end
                REQ, RESP: begin
                    // Timeout wins even if the bus handshakes in the same cycle.
                    if (timed_out) begin
                        err_reg     <= 1'b1;
                        wb_data_reg <= '0;
                        reg_wen_reg <= 1'b0;
                        state_reg   <= DONE;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                        if (state_reg == REQ) begin
                            if (bus.mem_req_ready) state_reg <= RESP;
                        end else if (bus.mem_resp_valid) begin
                            wb_data_reg <= wen_reg ? 32'd0 : load_value;
                            reg_wen_reg <= !wen_reg;
                            state_reg   <= DONE;
                        end
                    end
                end
                DONE: if (bus.out_ready) state_reg <= IDLE;
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign bus.in_ready      = (state_reg == IDLE);
    assign bus.out_valid     = (state_reg == DONE);
    assign bus.out_wb_data   = (state_reg == DONE) ? wb_data_reg : 32'd0;
    assign bus.out_reg_wen   = (state_reg == DONE) && reg_wen_reg;
    assign bus.out_err       = (state_reg == DONE) && err_reg;
    assign bus.mem_req_valid = (state_reg == REQ);
    assign bus.mem_req_addr  = {addr_reg[31:2], 2'b00};
    assign bus.mem_req_wen   = (state_reg == REQ) && wen_reg;
    assign bus.mem_req_wdata = wdata_reg;
    assign bus.mem_req_wmask = (state_reg == REQ) ? wmask_reg : 4'b0000;
endmodule

// File: tb/tb_ysyx_25020047_lsu.sv
// Directed bench for the LSU with hand-computed expectations; DUT built with TIMEOUT=8.
module tb_ysyx_25020047_lsu;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   err_cnt = 0;
    int   chk_cnt = 0;

    ysyx_25020047_lsu_if bus ();

    ysyx_25020047_lsu #(.TIMEOUT(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end else begin
            $display("ok   %s: %h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] res, input logic [31:0] wd, input logic rd,
                        input logic wr, input logic [1:0] sz, input logic uns, input logic rwen);
        check("accept_ready", 32'(bus.in_ready), 32'd1);
        bus.in_valid    = 1'b1;
        bus.in_result   = res;
        bus.in_wdata    = wd;
        bus.in_read     = rd;
        bus.in_write    = wr;
        bus.in_size     = sz;
        bus.in_unsigned = uns;
        bus.in_reg_wen  = rwen;
        tick();
        bus.in_valid = 1'b0;
        bus.in_read  = 1'b0;
        bus.in_write = 1'b0;
    endtask

    // Grant immediately, respond one cycle later, leave the LSU sitting in DONE.
    task automatic bus_cycle(input logic [31:0] rdata);
        bus.mem_req_ready = 1'b1;
        tick();
        bus.mem_req_ready  = 1'b0;
        bus.mem_resp_valid = 1'b1;
        bus.mem_resp_rdata = rdata;
        tick();
        bus.mem_resp_valid = 1'b0;
    endtask

    task automatic retire();
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        check("retire_in_ready", 32'(bus.in_ready), 32'd1);
    endtask

    initial begin
        bus.in_valid = 0; bus.in_result = 0; bus.in_wdata = 0; bus.in_read = 0;
        bus.in_write = 0; bus.in_size = 0; bus.in_unsigned = 0; bus.in_reg_wen = 0;
        bus.out_ready = 0; bus.mem_req_ready = 0; bus.mem_resp_valid = 0; bus.mem_resp_rdata = 0;

        tick(); tick();
        rst = 1'b0;
        check("rst_req_valid", 32'(bus.mem_req_valid), 32'd0);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out_err", 32'(bus.out_err), 32'd0);
        check("rst_reg_wen", 32'(bus.out_reg_wen), 32'd0);
        check("rst_wb_data", bus.out_wb_data, 32'd0);
        check("rst_wmask", 32'(bus.mem_req_wmask), 32'd0);
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);

        // Non-memory op
        send(32'h1234, 32'h0, 0, 0, 2'd2, 0, 1);
        check("alu_out_valid", 32'(bus.out_valid), 32'd1);
        check("alu_wb", bus.out_wb_data, 32'h0000_1234);
        check("alu_reg_wen", 32'(bus.out_reg_wen), 32'd1);
        check("alu_no_req", 32'(bus.mem_req_valid), 32'd0);
        check("alu_in_ready", 32'(bus.in_ready), 32'd0);
        retire();

        // lbu / lb at offset 3
        send(32'h8000_0003, 32'h0, 1, 0, 2'd0, 1, 1);
        check("lbu_req_valid", 32'(bus.mem_req_valid), 32'd1);
        check("lbu_addr", bus.mem_req_addr, 32'h8000_0000);
        check("lbu_wmask", 32'(bus.mem_req_wmask), 32'd0);
        check("lbu_wen", 32'(bus.mem_req_wen), 32'd0);
        bus_cycle(32'h80FF_7F11);
        check("lbu_out_valid", 32'(bus.out_valid), 32'd1);
        check("lbu_wb", bus.out_wb_data, 32'h0000_0080);
        check("lbu_reg_wen", 32'(bus.out_reg_wen), 32'd1);
        retire();
        send(32'h8000_0003, 32'h0, 1, 0, 2'd0, 0, 1);
        check("lb_addr", bus.mem_req_addr, 32'h8000_0000);
        check("lb_wmask", 32'(bus.mem_req_wmask), 32'd0);
        bus_cycle(32'h80FF_7F11);
        check("lb_wb", bus.out_wb_data, 32'hFFFF_FF80);
        check("lb_err", 32'(bus.out_err), 32'd0);
        retire();

        // lb at offset 1 (positive byte), lh/lhu at offset 2
        send(32'h8000_0001, 32'h0, 1, 0, 2'd0, 0, 1);
        bus_cycle(32'h80FF_7F11);
        check("lb1_wb", bus.out_wb_data, 32'h0000_007F);
        retire();
        send(32'h8000_0002, 32'h0, 1, 0, 2'd1, 0, 1);
        bus_cycle(32'h8001_1234);
        check("lh_wb", bus.out_wb_data, 32'hFFFF_8001);
        retire();
        send(32'h8000_0002, 32'h0, 1, 0, 2'd1, 1, 1);
        bus_cycle(32'h8001_1234);
        check("lhu_wb", bus.out_wb_data, 32'h0000_8001);
        retire();

        // sb at offset 2
        send(32'h8000_0002, 32'hDEAD_BEEF, 0, 1, 2'd0, 0, 0);
        check("sb_wmask", 32'(bus.mem_req_wmask), 32'h4);
        check("sb_wdata", bus.mem_req_wdata, 32'hEFEF_EFEF);
        check("sb_wen", 32'(bus.mem_req_wen), 32'd1);
        check("sb_addr", bus.mem_req_addr, 32'h8000_0000);
        bus_cycle(32'h0);
        check("sb_out_valid", 32'(bus.out_valid), 32'd1);
        check("sb_reg_wen", 32'(bus.out_reg_wen), 32'd0);
        check("sb_err", 32'(bus.out_err), 32'd0);
        check("sb_wb", bus.out_wb_data, 32'd0);
        retire();

        // sh at offset 2, sw aligned
        send(32'h8000_0006, 32'hCAFE_1234, 0, 1, 2'd1, 0, 0);
        check("sh_wmask", 32'(bus.mem_req_wmask), 32'hC);
        check("sh_wdata", bus.mem_req_wdata, 32'h1234_1234);
        bus_cycle(32'h0);
        retire();
        send(32'h8000_0008, 32'hCAFE_1234, 0, 1, 2'd2, 0, 0);
        check("sw_wmask", 32'(bus.mem_req_wmask), 32'hF);
        check("sw_wdata", bus.mem_req_wdata, 32'hCAFE_1234);
        check("sw_addr", bus.mem_req_addr, 32'h8000_0008);
        bus_cycle(32'h0);
        retire();

        // Fault cases: misaligned half, misaligned word, read&write, illegal size
        send(32'h8000_0001, 32'h0, 0, 1, 2'd1, 0, 0);
        check("sh_mis_err", 32'(bus.out_err), 32'd1);
        check("sh_mis_valid", 32'(bus.out_valid), 32'd1);
        check("sh_mis_noreq", 32'(bus.mem_req_valid), 32'd0);
        retire();
        send(32'h8000_0006, 32'h0, 1, 0, 2'd2, 0, 1);
        check("lw_mis_err", 32'(bus.out_err), 32'd1);
        check("lw_mis_reg_wen", 32'(bus.out_reg_wen), 32'd0);
        check("lw_mis_wb", bus.out_wb_data, 32'd0);
        check("lw_mis_noreq", 32'(bus.mem_req_valid), 32'd0);
        retire();
        send(32'h8000_0000, 32'h0, 1, 1, 2'd2, 0, 1);
        check("rw_err", 32'(bus.out_err), 32'd1);
        retire();
        send(32'h8000_0000, 32'h0, 1, 0, 2'd3, 0, 1);
        check("size3_err", 32'(bus.out_err), 32'd1);
        retire();

        // Request stall for 3 cycles, then normal completion
        send(32'h8000_0004, 32'h0, 1, 0, 2'd2, 0, 1);
        for (int i = 0; i < 3; i++) begin
            check("stall_valid", 32'(bus.mem_req_valid), 32'd1);
            check("stall_addr", bus.mem_req_addr, 32'h8000_0004);
            bus.mem_resp_valid = 1'b1;  // must be ignored while in REQ
            bus.mem_resp_rdata = 32'hBAD0_BAD0;
            tick();
        end
        bus.mem_resp_valid = 1'b0;
        check("stall_still_req", 32'(bus.mem_req_valid), 32'd1);
        bus_cycle(32'h1234_5678);
        check("stall_wb", bus.out_wb_data, 32'h1234_5678);
        check("stall_err", 32'(bus.out_err), 32'd0);
        retire();

        // Timeout: REQ entered at the accept edge, error 8 cycles later
        send(32'h8000_0000, 32'h0, 1, 0, 2'd2, 0, 1);
        repeat (7) tick();
        check("to_not_yet", 32'(bus.out_valid), 32'd0);
        tick();
        check("to_valid", 32'(bus.out_valid), 32'd1);
        check("to_err", 32'(bus.out_err), 32'd1);
        check("to_noreq", 32'(bus.mem_req_valid), 32'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("hold_valid", 32'(bus.out_valid), 32'd1);
            check("hold_err", 32'(bus.out_err), 32'd1);
            check("hold_in_ready", 32'(bus.in_ready), 32'd0);
        end
        retire();

        // Reset while waiting for the response
        send(32'h8000_0000, 32'h0, 1, 0, 2'd2, 0, 1);
        bus.mem_req_ready = 1'b1;
        tick();
        bus.mem_req_ready = 1'b0;
        check("mid_in_resp", 32'(bus.mem_req_valid), 32'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_req", 32'(bus.mem_req_valid), 32'd0);
        check("mid_rst_out", 32'(bus.out_valid), 32'd0);
        check("mid_rst_ready", 32'(bus.in_ready), 32'd1);
        check("mid_rst_wb", bus.out_wb_data, 32'd0);
        bus.mem_resp_valid = 1'b1;
        bus.mem_resp_rdata = 32'h5555_AAAA;
        tick();
        bus.mem_resp_valid = 1'b0;
        check("late_resp_out", 32'(bus.out_valid), 32'd0);
        tick();
        check("late_resp_idle", 32'(bus.in_ready), 32'd1);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
